ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. It is the next generation of the team's keyboard input block and adds:
- input synchronisation and glitch filtering
- odd-parity and stop-bit checking
- a frame watchdog
- a buffered FIFO output with a valid/ready handshake

It sits between the board PS/2 pins and game-control logic. Consumers pop bytes at their own pace instead of catching a one-cycle pulse.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_fifo.sv | 62 ++++++
 rtl/ps2_rx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver slice.
// PS2_SCANCODE_DECODE_EN widens FIFO entries to carry the break/extended flags.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

`ifdef PS2_SCANCODE_DECODE_EN
    localparam int PS2_ENTRY_W = 10;
`else
    localparam int PS2_ENTRY_W = 8;
`endif

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == cnt_t'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync/filter, framing FSM with watchdog, FIFO output.
// Define PS2_SCANCODE_DECODE_EN to fold E0/F0 prefixes into {brk, ext, byte} entries.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [PS2_ENTRY_W-1:0]        rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clear_overflow
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef logic [FCW-1:0] fcnt_t;
    typedef logic [WDW-1:0] wd_t;

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    fcnt_t      flt_cnt [2];
    logic       clk_filt_d;
    logic       fall;
    logic       data_bit;

    assign raw      = {ps2_data, ps2_clk};
    assign fall     = clk_filt_d & ~filt[0];
    assign data_bit = filt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '1;
            sync2      <= '1;
            filt       <= '1;
            clk_filt_d <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            clk_filt_d <= filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == fcnt_t'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + fcnt_t'(1);
                end
            end
        end
    end

    ps2_state_t state;
    ps2_state_t state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    wd_t        wd_cnt;
    logic       shift_en;
    logic       cap_par;
    logic       done_ok;
    logic       done_perr;
    logic       done_ferr;
    logic       timeout;
    logic       par_ok;

    assign par_ok = ^{shreg, par_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cap_par    = 1'b0;
        done_ok    = 1'b0;
        done_perr  = 1'b0;
        done_ferr  = 1'b0;
        timeout    = 1'b0;
        if (state != IDLE && wd_cnt == wd_t'(TIMEOUT_CYCLES - 1)) begin
            timeout    = 1'b1;
            state_next = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    cap_par    = 1'b1;
                    state_next = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (!par_ok) begin
                        done_perr = 1'b1;
                    end else if (!data_bit) begin
                        done_ferr = 1'b1;
                    end else begin
                        done_ok = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= done_perr;
            frame_err  <= done_ferr | timeout;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shreg <= {data_bit, shreg[7:1]};
            end
            if (cap_par) begin
                par_bit <= data_bit;
            end
            if (state == IDLE || fall) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + wd_t'(1);
            end
        end
    end

    logic                   push_req;
    logic [PS2_ENTRY_W-1:0] push_entry;

`ifdef PS2_SCANCODE_DECODE_EN
    logic ext;
    logic brk;
    logic is_ext;
    logic is_brk;

    assign is_ext = (shreg == PS2_PREFIX_EXT);
    assign is_brk = (shreg == PS2_PREFIX_BRK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= done_ok && !is_ext && !is_brk;
            if (done_ok) begin
                push_entry <= {brk, ext, shreg};
            end
            if (done_perr || done_ferr || timeout) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (done_ok) begin
                if (is_ext) begin
                    ext <= 1'b1;
                end else if (is_brk) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= done_ok;
            if (done_ok) begin
                push_entry <= shreg;
            end
        end
    end
`endif

    logic pop;
    logic full;
    logic empty;

    assign pop      = rd_valid && rd_ready;
    assign rd_valid = !empty;

    ps2_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .head      (rd_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    // A new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames driven on the pins, expected
// FIFO entries queued at send time and compared as they are popped.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;
    localparam int DEPTH      = 8;
    localparam int HALF       = 20;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   ps2_clk = 1'b1;
    logic                   ps2_data = 1'b1;
    logic                   rd_ready = 1'b0;
    logic                   clear_overflow = 1'b0;
    logic                   rd_valid;
    logic [PS2_ENTRY_W-1:0] rd_data;
    logic [CW-1:0]          fifo_count;
    logic                   parity_err;
    logic                   frame_err;
    logic                   overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ferr_cyc = 0;
    int last_fall = 0;
    logic perr_prev = 1'b0;
    logic ferr_prev = 1'b0;

    logic [PS2_ENTRY_W-1:0] exp_q[$];
    int   model_cnt = 0;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    logic exp_ovf = 1'b0;

    ps2_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .fifo_count     (fifo_count),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error outputs must be single-cycle pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) begin
                perr_cnt++;
                check("perr_single", {31'd0, perr_prev}, 0);
            end
            if (frame_err) begin
                ferr_cnt++;
                ferr_cyc = cyc;
                check("ferr_single", {31'd0, ferr_prev}, 0);
            end
        end
        perr_prev = parity_err;
        ferr_prev = frame_err;
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
        ps2_bit(stop);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        logic [PS2_ENTRY_W-1:0] e;
        logic                   do_push;
`ifdef PS2_SCANCODE_DECODE_EN
        do_push = 1'b0;
        e = '0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            do_push = 1'b1;
            e = {m_brk, m_ext, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
`else
        do_push = 1'b1;
        e = b;
`endif
        if (do_push) begin
            if (model_cnt < DEPTH) begin
                exp_q.push_back(e);
                model_cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b, input logic par_flip, input logic stop);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_frame(b, par_flip, stop);
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic [PS2_ENTRY_W-1:0] e;
        n = 0;
        while (!rd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, rd_valid}, 1);
        check({tag, "_queued"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 1);
        if (rd_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_cnt--;
            check(tag, {22'd0, rd_data}, {22'd0, e});
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_cnt = 0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        int p0;
        int f0;
        int n;
        int lat;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", {31'd0, rd_valid}, 0);
        check("rst_data", {22'd0, rd_data}, 0);
        check("rst_count", {28'd0, fifo_count}, 0);
        check("rst_perr", {31'd0, parity_err}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Basic good frame and pop.
        send_good(8'h1C);
        check("good_count", {28'd0, fifo_count}, model_cnt);
        pop_check("good_1c");
        @(negedge clk);
        check("good_empty", {31'd0, rd_valid}, 0);

        // Parity error, then stop-bit error.
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send_bad(8'h1C, 1'b1, 1'b1);
        check("perr_pulse", perr_cnt, p0 + 1);
        check("perr_nopush", {28'd0, fifo_count}, 0);
        send_bad(8'h1C, 1'b0, 1'b0);
        check("ferr_pulse", ferr_cnt, f0 + 1);
        check("ferr_noperr", perr_cnt, p0 + 1);
        check("ferr_nopush", {28'd0, fifo_count}, 0);
        // Both bad: parity wins.
        send_bad(8'h1C, 1'b1, 1'b0);
        check("prio_perr", perr_cnt, p0 + 2);
        check("prio_noferr", ferr_cnt, f0 + 1);

        // Watchdog: start + 3 data bits, then clock stays high.
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        n = 0;
        while (ferr_cnt == f0 && n < TIMEOUT + 200) begin
            @(negedge clk);
            n++;
        end
        check("wd_seen", ferr_cnt, f0 + 1);
        lat = ferr_cyc - last_fall;
        check("wd_latency", (lat >= TIMEOUT && lat <= TIMEOUT + FILTER_LEN + 10) ? 32'd1 : 32'd0, 1);
        check("wd_nopush", {28'd0, fifo_count}, 0);
        repeat (20) @(negedge clk);
        send_good(8'h75);
        pop_check("after_wd_75");

        // Short clock glitch in IDLE with data low must not start a frame.
        p0 = perr_cnt;
        f0 = ferr_cnt;
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_nopush", {28'd0, fifo_count}, 0);
        send_good(8'h2A);
        pop_check("after_glitch_2a");
        check("glitch_noferr", ferr_cnt, f0);
        check("glitch_noperr", perr_cnt, p0);

        // Fill to depth, then one more frame overflows.
        for (int i = 1; i <= DEPTH; i++) send_good(8'(i));
        check("full_count", {28'd0, fifo_count}, model_cnt);
        check("full_noovf", {31'd0, overflow}, {31'd0, exp_ovf});
        send_good(8'(DEPTH + 1));
        check("ovf_count", {28'd0, fifo_count}, model_cnt);
        check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
        for (int i = 1; i <= DEPTH; i++) pop_check("ovf_drain");
        check("ovf_sticky", {31'd0, overflow}, {31'd0, exp_ovf});
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clear", {31'd0, overflow}, {31'd0, exp_ovf});

        // Prefix handling (raw bytes without decode).
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("pref_count", {28'd0, fifo_count}, model_cnt);
        while (exp_q.size() > 0) pop_check("pref_seq");
        send_good(8'h1C);
        pop_check("plain_1c");
        send_good(8'hF0);
        send_bad(8'h33, 1'b1, 1'b1);
        send_good(8'h1C);
        while (exp_q.size() > 0) pop_check("flag_clear");
        send_good(8'hE1);
        pop_check("e1_plain");

        // Reset mid-frame: no error pulse, FIFO empty afterwards.
        send_good(8'h55);
        f0 = ferr_cnt;
        p0 = perr_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        ps2_data = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("midrst_count", {28'd0, fifo_count}, 0);
        rst_n = 1'b1;
        repeat (TIMEOUT + 20) @(negedge clk);
        check("midrst_noferr", ferr_cnt, f0);
        check("midrst_noperr", perr_cnt, p0);
        send_good(8'hA5);
        pop_check("after_rst_a5");

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
